// File: rtl/mult_div_unit.sv
// Iterative 33-cycle MULT/MULTU/DIV/DIVU engine that owns the architectural HI/LO pair.
// Signed ops are done on magnitudes and then sign-corrected in a single FIX cycle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Flush,
   input  logic             HiWrite,
   input  logic             LoWrite,
   input  logic [WIDTH-1:0] WriteData,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [5:0]         r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opd;
   logic               r_is_div;
   logic               r_neg_lo;
   logic               r_neg_hi;
   logic               r_div0;

   logic               w_accept;
   logic               w_signed;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_add;
   logic [2*WIDTH-1:0] w_mul_nxt;
   logic [WIDTH:0]     w_part;
   logic               w_ge;
   logic [WIDTH-1:0]   w_sub;
   logic [2*WIDTH-1:0] w_div_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

   function automatic logic [WIDTH-1:0] f_cneg32(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] f_cneg64(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   assign w_accept = Start && !Flush;
   assign w_signed = ~Op[0];
   assign w_mag_a  = f_cneg32(A, w_signed & A[WIDTH-1]);
   assign w_mag_b  = f_cneg32(B, w_signed & B[WIDTH-1]);

   // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right.
   assign w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opd : {WIDTH{1'b0}})};
   assign w_mul_nxt = {w_add, r_acc[WIDTH-1:1]};

   // Divide step: upper half is the partial remainder, lower half shifts dividend out / quotient in.
   assign w_part    = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_ge      = (w_part >= {1'b0, r_opd});
   assign w_sub     = w_part[WIDTH-1:0] - r_opd;
   assign w_div_nxt = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1}
                           : {w_part[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

   assign w_prod   = f_cneg64(r_acc, r_neg_lo);
   assign w_quo    = r_div0 ? {WIDTH{1'b1}} : f_cneg32(r_acc[WIDTH-1:0], r_neg_lo);
   assign w_rem    = f_cneg32(r_acc[2*WIDTH-1:WIDTH], r_neg_hi);
   assign w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
   assign w_res_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_RUN;
         S_RUN: begin
            if (Flush)               w_state_nxt = S_IDLE;
            else if (r_cnt == 6'd31) w_state_nxt = S_FIX;
         end
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 6'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= (r_state == S_FIX) && !Flush;
         if (r_state == S_RUN) r_cnt <= r_cnt + 6'd1;
         else                  r_cnt <= 6'd0;
      end
   end

   // MT writes only land while idle; a FIX result overwrites any earlier MT write.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_hi <= {WIDTH{1'b0}};
         r_lo <= {WIDTH{1'b0}};
      end else if (r_state == S_IDLE) begin
         if (HiWrite) r_hi <= WriteData;
         if (LoWrite) r_lo <= WriteData;
      end else if ((r_state == S_FIX) && !Flush) begin
         r_hi <= w_res_hi;
         r_lo <= w_res_lo;
      end
   end

   always_ff @(posedge Clk) begin
      if ((r_state == S_IDLE) && w_accept) begin
         r_is_div <= Op[1];
         r_div0   <= (B == {WIDTH{1'b0}});
         r_neg_lo <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
         r_neg_hi <= w_signed & A[WIDTH-1];
         r_acc    <= {{WIDTH{1'b0}}, (Op[1] ? w_mag_a : w_mag_b)};
         r_opd    <= Op[1] ? w_mag_b : w_mag_a;
      end else if (r_state == S_RUN) begin
         r_acc    <= r_is_div ? w_div_nxt : w_mul_nxt;
      end
   end

   assign Busy = r_busy;
   assign Done = r_done;
   assign Hi   = r_hi;
   assign Lo   = r_lo;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit serving the EX stage of the pipelined MIPS datapath. It executes MULT, MULTU, DIV and DIVU over 33 cycles and holds the architectural HI and LO registers that MFHI/MFLO read and MTHI/MTLO write. While it is running it raises Busy, which the hazard logic uses to stall IF/ID/EX. The operands are EX_Read1 and EX_Read2. The unit sits alongside the ALU and feeds the EX_MEM result path through Hi and Lo.

## Interface
- WIDTH, 32, operand and HI/LO width (only 32 is supported)
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- Start  in  1  request to begin an operation; sampled only in IDLE
- Op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  in  32  rs operand (multiplicand / dividend)
- B  in  32  rt operand (multiplier / divisor)
- Flush  in  1  cancel the in-flight operation (squash from branch/jump)
- HiWrite  in  1  MTHI: load Hi from WriteData
- LoWrite  in  1  MTLO: load Lo from WriteData
- WriteData  in  32  MTHI/MTLO data
- Busy  out  1  operation in progress; pipeline must stall MF*/MT*/mult/div
- Done  out  1  one-cycle pulse when Hi/Lo are updated by an operation
- Hi  out  32  HI register (remainder / product[63:32])
- Lo  out  32  LO register (quotient / product[31:0])

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - On Start, capture |A| and |B|; the signed ops take the magnitude of each operand, the unsigned ops use the raw values.
  - Record the result sign bits: product sign = A[31]^B[31]; quotient sign = A[31]^B[31]; remainder sign = A[31]. These apply to the signed ops only.
  - Clear the 6-bit iteration counter and go to RUN.
- RUN: one iteration per cycle, with the counter running 0..31; at count 31, go to FIX.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract with a 32-bit remainder and quotient.
- FIX:
  - Negate the results in two's complement where the recorded sign requires it.
  - Write Hi/Lo, pulse Done, and return to IDLE.
- Divide by zero (B==0), unsigned or signed: Lo=0xFFFFFFFF, Hi=A. No trap; latency is unchanged.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0x00000000. This falls out of the magnitude algorithm.
- Start while Busy: ignored, with no queueing.
- HiWrite/LoWrite:
  - In IDLE they are applied at the edge.
  - While Busy (RUN/FIX) they are ignored.
  - If HiWrite/LoWrite arrive together with Start in IDLE, the MT write takes effect at that edge and the later FIX result overwrites it.
- Flush:
  - In RUN or FIX, the unit returns to IDLE at the next edge. Hi/Lo are unchanged and Done stays 0.
  - In IDLE, Flush has priority over Start; the operation is not started.
- Hi/Lo are otherwise held indefinitely.

## Timing
- Reset (async, while Reset=0): state=IDLE, counter=0, Hi=0, Lo=0, Busy=0, Done=0. Release is synchronous to the next Clk edge.
- Edge E0: Start sampled in IDLE, then Busy=1.
- Edges E1..E32: 32 iterations.
- Edge E33: FIX, with Hi/Lo valid, Done=1 and Busy=0 after E33.
- Latency: 33 cycles from the Start edge to Hi/Lo update. Busy is high for exactly 33 cycles.
- Done: high for exactly one cycle, after E33.
- Back-to-back: Start may be asserted in the Done cycle and is accepted at E34.
- Busy is a registered output, derived from state != IDLE. Done is registered.
- Reset asserted mid-operation aborts immediately: all outputs go to their reset values and the previous Hi/Lo are lost.
- MT write: Hi/Lo updated at the accepting edge and visible the following cycle.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles: Hi=0xFFFFFFFE, Lo=0x00000001, one Done pulse, Busy high for 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU A=0x12345678, B=0 -> Lo=0xFFFFFFFF, Hi=0x12345678. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MTHI 0xAAAA0000 and MTLO 0x5555 in IDLE -> Hi/Lo updated next cycle. Start DIVU 100/7, then pulse Start again and HiWrite during RUN -> both ignored, final Lo=14, Hi=2.
- Set Hi/Lo=0x11/0x22, start MULTU 3*5, assert Flush at E10 -> Busy=0 after E11, no Done, Hi/Lo still 0x11/0x22. Next Start completes normally with Lo=15.
- Start MULT, drive Reset=0 asynchronously mid-cycle at iteration 20 -> Busy, Done, Hi and Lo go to 0 immediately, without waiting for an edge. After release, a new MULTU 2*3 gives Lo=6 at E33.
